dsram_responder: RTL and testbench
==================================

DSRAM_RESPONDER -- requirements
Module: dsram_responder

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, meaning word-address width; depth is 2^ADDR_W 32-bit words (4 KB at default).
REQ-002 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst  input  1  reset; asynchronous, active-high.
REQ-004 SHALL have port en  input  1  access request this cycle.
REQ-005 SHALL have port we  input  1  1 = write, 0 = read; ignored when en=0.
REQ-006 SHALL have port sel  input  4  byte-lane write enables; sel[i] writes wdata[8i+7:8i].
REQ-007 SHALL have port addr  input  32  byte address; word index = addr[ADDR_W+1:2]; addr[1:0] ignored.
REQ-008 SHALL have port wdata  input  32  write data, lane-aligned by the initiator.
REQ-009 SHALL have port rdata  output  32  registered read data.
REQ-010 SHALL have port busy  output  1  1 while the post-reset clear is in progress; requests ignored.
REQ-011 SHALL have port addr_err  output  1  registered one-cycle flag: previous accepted request was out of range.

Function
REQ-012 Accepted request: en=1 and busy=0 at a rising edge.
REQ-013 Out-of-range: addr[31:ADDR_W+2] nonzero; such a request SHALL NOT modify memory, SHALL load rdata with 0 and SHALL set addr_err=1 for exactly the next cycle.
REQ-014 In-range accepted read: rdata SHALL equal mem[index] from the cycle after the request (latency 1) and hold until the next accepted read or out-of-range request.
REQ-015 In-range accepted write: only lanes with sel[i]=1 SHALL update; sel=0000 is a no-op; rdata SHALL hold its previous value.
REQ-016 Read in cycle N+1 of a word written in cycle N SHALL return the newly written bytes merged with the unwritten old bytes (write-first ordering, no bubble).
REQ-017 addr_err SHALL be 0 after any in-range accepted request, any cycle with en=0, and any cycle with busy=1.
REQ-018 Requests while busy=1 SHALL be dropped: no memory update, rdata held at 0, addr_err=0.
REQ-019 Clear FSM states: CLEAR and RUN. CLEAR writes 0 to word cnt, increments cnt each cycle, and moves to RUN after writing word 2^ADDR_W-1. RUN is terminal until reset.
REQ-020 busy SHALL be 1 exactly while in CLEAR, i.e. for 2^ADDR_W cycles after reset release; the first request is accepted in the first RUN cycle.
REQ-021 cnt SHALL be ADDR_W bits wide; terminal detection SHALL use all-ones and SHALL NOT rely on wrap-around.

Reset
REQ-022 On rst=1: rdata=0, addr_err=0, cnt=0, and the FSM SHALL enter CLEAR (busy=1) when clear is compiled in, RUN (busy=0) otherwise.
REQ-023 Reset asserted mid-clear SHALL restart the clear from word 0.
REQ-024 Memory array contents SHALL NOT be reset directly; only the clear FSM initialises them.

Configuration
REQ-025 Macro DSRAM_CLEAR_EN: when defined, the CLEAR state and counter are present per REQ-019..REQ-023.
REQ-026 When DSRAM_CLEAR_EN is undefined: no FSM or counter, busy tied 0, requests accepted from the first cycle after reset, memory contents undefined until written.

Verification
REQ-027 ADDR_W=4, DSRAM_CLEAR_EN defined; release reset -> busy=1 for 16 cycles then 0; read of each of words 0..15 returns 0x00000000.
REQ-028 Write addr 0x8, sel=1111, wdata=0xDEADBEEF; read addr 0x8 next cycle -> rdata=0xDEADBEEF one cycle after the read.
REQ-029 Write 0x11223344 to addr 0x4, then sel=0100 with wdata=0x00AA0000 -> read returns 0x11AA3344; sel=0000 write leaves it unchanged.
REQ-030 Read addr 0x00000040 (ADDR_W=4) -> addr_err=1 for one cycle, rdata=0, memory unchanged; the following in-range read clears addr_err.
REQ-031 Assert rst at clear cycle 7, release -> busy=1 for a full 16 further cycles; a request issued during busy has no effect.
REQ-032 DSRAM_CLEAR_EN undefined -> busy=0 immediately after reset; write/read at addr 0x0 in the first two cycles returns the written data.

Source files
------------

// File: rtl/dsram_responder.sv
// -----------------------------------------------------------------------------
// dsram_responder
//   Single-port 32-bit data SRAM slave with byte-lane writes, one-cycle
//   registered read latency and an out-of-range flag. Depth is 2^ADDR_W words.
//
//   Optional build macro: DSRAM_CLEAR_EN
//     defined   -> after reset a CLEAR/RUN FSM zeroes every word, one per
//                  cycle, and holds busy high until the sweep finishes.
//     undefined -> no FSM, busy tied low, contents undefined until written.
//
//   Ports
//     clk      in   1   rising-edge clock
//     rst      in   1   asynchronous active-high reset
//     en       in   1   access request this cycle
//     we       in   1   1 = write, 0 = read
//     sel      in   4   byte-lane write enables
//     addr     in  32   byte address (word index = addr[ADDR_W+1:2])
//     wdata    in  32   write data, lane aligned
//     rdata    out 32   registered read data
//     busy     out  1   post-reset clear in progress; requests dropped
//     addr_err out  1   previous accepted request was out of range
// -----------------------------------------------------------------------------
module dsram_responder #(
  parameter int ADDR_W = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        we,
  input  logic [3:0]  sel,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        busy,
  output logic        addr_err
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [31:0]       mem [DEPTH];

  logic [ADDR_W-1:0] req_idx;
  logic              out_of_range;
  logic              accept;

  logic              clr_we;
  logic [ADDR_W-1:0] clr_idx;

  logic [ADDR_W-1:0] wr_idx;
  logic [3:0]        wr_lane;
  logic [31:0]       wr_data;

  logic [31:0]       rdata_q;
  logic              addr_err_q;

  // Byte offset bits never select anything; word accesses only.
  logic              unused_addr_lsbs;
  assign unused_addr_lsbs = &{1'b0, addr[1:0]};

  assign req_idx      = addr[ADDR_W+1:2];
  assign out_of_range = |addr[31:ADDR_W+2];
  assign accept       = en & ~busy;

`ifdef DSRAM_CLEAR_EN
  typedef enum logic {CLEAR, RUN} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= CLEAR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // The counter stops on the last word instead of wrapping, so leaving
  // CLEAR depends only on the all-ones compare.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    clr_we  = 1'b0;
    if (state_q == CLEAR) begin
      clr_we = 1'b1;
      if (cnt_q == '1) begin
        state_d = RUN;
      end else begin
        cnt_d = cnt_q + ADDR_W'(1);
      end
    end
  end

  assign busy    = (state_q == CLEAR);
  assign clr_idx = cnt_q;
`else
  assign busy    = 1'b0;
  assign clr_we  = 1'b0;
  assign clr_idx = '0;
`endif

  // Clear sweep and initiator writes share the single write port; they can
  // never collide because requests are dropped while clearing.
  assign wr_idx = clr_we ? clr_idx : req_idx;

  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign wr_lane[gi]        = clr_we | (accept & we & ~out_of_range & sel[gi]);
    assign wr_data[8*gi +: 8] = clr_we ? 8'h00 : wdata[8*gi +: 8];
  end

  // Memory array: no reset, contents only set by writes or the clear sweep.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (wr_lane[i]) begin
        mem[wr_idx][8*i +: 8] <= wr_data[8*i +: 8];
      end
    end
  end

  // Registered read: a read the cycle after a write sees the updated word
  // because the write has already landed in the array at that edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_q    <= '0;
      addr_err_q <= 1'b0;
    end else begin
      addr_err_q <= accept & out_of_range;
      if (accept && out_of_range) begin
        rdata_q <= '0;
      end else if (accept && !we) begin
        rdata_q <= mem[req_idx];
      end
    end
  end

  assign rdata    = rdata_q;
  assign addr_err = addr_err_q;

endmodule

// File: tb/tb_dsram_responder.sv
module tb_dsram_responder;

  localparam int AW    = 4;
  localparam int WORDS = 1 << AW;

`ifdef DSRAM_CLEAR_EN
  localparam logic CLEAR_BUILD = 1'b1;
`else
  localparam logic CLEAR_BUILD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic        we = 1'b0;
  logic [3:0]  sel = 4'h0;
  logic [31:0] addr = 32'h0;
  logic [31:0] wdata = 32'h0;
  logic [31:0] rdata;
  logic        busy;
  logic        addr_err;

  always #5 clk = ~clk;

  dsram_responder #(.ADDR_W(AW)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .we       (we),
    .sel      (sel),
    .addr     (addr),
    .wdata    (wdata),
    .rdata    (rdata),
    .busy     (busy),
    .addr_err (addr_err)
  );

  int passed = 0;
  int total  = 0;

  // Reference model: word-addressed array plus expected output registers.
  logic [31:0] ref_mem [WORDS];
  logic [31:0] ref_rdata = 32'h0;
  logic        ref_err   = 1'b0;

  task automatic model_step(input logic e, input logic w, input logic [3:0] s,
                            input logic [31:0] a, input logic [31:0] d);
    logic [31:0] mask;
    int          word;
    if (!e) begin
      ref_err = 1'b0;
    end else if (a >= 32'(4 * WORDS)) begin
      ref_rdata = 32'h0;
      ref_err   = 1'b1;
    end else begin
      word    = int'(a / 4);
      ref_err = 1'b0;
      if (w) begin
        mask = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
        ref_mem[word] = (ref_mem[word] & ~mask) | (d & mask);
      end else begin
        ref_rdata = ref_mem[word];
      end
    end
  endtask

  // One transaction per clock; inputs change 1 time unit after the edge and
  // outputs are sampled at the same point, well clear of the active edge.
  task automatic drive(input logic e, input logic w, input logic [3:0] s,
                       input logic [31:0] a, input logic [31:0] d);
    logic was_busy;
    en = e; we = w; sel = s; addr = a; wdata = d;
    was_busy = busy;
    @(posedge clk);
    #1;
    if (!was_busy) model_step(e, w, s, a, d);
    else ref_err = 1'b0;
    $display("[%0t] txn en=%0b we=%0b sel=%b addr=%h wdata=%h -> rdata=%h addr_err=%0b busy=%0b",
             $time, e, w, s, a, d, rdata, addr_err, busy);
    en = 1'b0;
  endtask

  task automatic release_reset();
    rst = 1'b0;
    ref_rdata = 32'h0;
    ref_err   = 1'b0;
  endtask

  // Counts busy cycles after a reset release while hammering a write that
  // must be dropped. Returns number of busy cycles seen.
  task automatic wait_clear(output int n);
    n = 0;
    en = 1'b1; we = 1'b1; sel = 4'hF; addr = 32'h8; wdata = 32'hFFFF_FFFF;
    while (busy === 1'b1 && n < 64) begin
      total++;
      if (rdata !== 32'h0 || addr_err !== 1'b0)
        $display("FAIL busy_outputs rdata=%h addr_err=%0b required 0/0", rdata, addr_err);
      else passed++;
      @(posedge clk);
      #1;
      n++;
    end
    en = 1'b0;
    $display("[%0t] clear done after %0d busy cycles", $time, n);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #2;
    total++;
    if (rdata !== 32'h0) $display("FAIL reset_rdata got %h required 0", rdata);
    else passed++;
    total++;
    if (addr_err !== 1'b0) $display("FAIL reset_addr_err got %0b required 0", addr_err);
    else passed++;
    total++;
    if (busy !== CLEAR_BUILD) $display("FAIL reset_busy got %0b required %0b", busy, CLEAR_BUILD);
    else passed++;
    @(posedge clk);
    #1;
  endtask

  task automatic test_startup();
    int n;
    release_reset();
`ifdef DSRAM_CLEAR_EN
    wait_clear(n);
    total++;
    if (n != WORDS) $display("FAIL clear_length got %0d required %0d", n, WORDS);
    else passed++;
    for (int i = 0; i < WORDS; i++) ref_mem[i] = 32'h0;
    for (int i = 0; i < WORDS; i++) begin
      drive(1'b1, 1'b0, 4'h0, 32'(4 * i), 32'h0);
      total++;
      if (rdata !== 32'h0) $display("FAIL clear_read word %0d got %h required 0", i, rdata);
      else passed++;
    end
`else
    n = 0;
    total++;
    if (busy !== 1'b0) $display("FAIL no_clear_busy got %0b required 0", busy);
    else passed++;
    drive(1'b1, 1'b1, 4'hF, 32'h0, 32'hC0FF_EE01);
    drive(1'b1, 1'b0, 4'h0, 32'h0, 32'h0);
    total++;
    if (rdata !== 32'hC0FF_EE01) $display("FAIL no_clear_first_rw got %h required c0ffee01", rdata);
    else passed++;
    for (int i = 0; i < WORDS; i++) drive(1'b1, 1'b1, 4'hF, 32'(4 * i), $urandom);
`endif
  endtask

  task automatic test_full_write();
    drive(1'b1, 1'b1, 4'hF, 32'h8, 32'hDEAD_BEEF);
    drive(1'b1, 1'b0, 4'h0, 32'h8, 32'h0);
    total++;
    if (rdata !== 32'hDEAD_BEEF) $display("FAIL full_write got %h required deadbeef", rdata);
    else passed++;
  endtask

  task automatic test_byte_lanes();
    drive(1'b1, 1'b1, 4'hF, 32'h4, 32'h1122_3344);
    drive(1'b1, 1'b1, 4'b0100, 32'h4, 32'h00AA_0000);
    drive(1'b1, 1'b0, 4'h0, 32'h4, 32'h0);
    total++;
    if (rdata !== 32'h11AA_3344) $display("FAIL lane_merge got %h required 11aa3344", rdata);
    else passed++;
    drive(1'b1, 1'b1, 4'h0, 32'h4, 32'hFFFF_FFFF);
    total++;
    if (rdata !== 32'h11AA_3344) $display("FAIL write_holds_rdata got %h required 11aa3344", rdata);
    else passed++;
    drive(1'b1, 1'b0, 4'h0, 32'h4, 32'h0);
    total++;
    if (rdata !== 32'h11AA_3344) $display("FAIL sel0_noop got %h required 11aa3344", rdata);
    else passed++;
  endtask

  task automatic test_out_of_range();
    drive(1'b1, 1'b0, 4'h0, 32'h40, 32'h0);
    total++;
    if (addr_err !== 1'b1 || rdata !== 32'h0)
      $display("FAIL oor_read addr_err=%0b rdata=%h required 1/0", addr_err, rdata);
    else passed++;
    drive(1'b1, 1'b1, 4'hF, 32'h44, 32'hFFFF_FFFF);
    total++;
    if (addr_err !== 1'b1) $display("FAIL oor_write addr_err got %0b required 1", addr_err);
    else passed++;
    drive(1'b1, 1'b0, 4'h0, 32'h4, 32'h0);
    total++;
    if (addr_err !== 1'b0 || rdata !== 32'h11AA_3344)
      $display("FAIL oor_no_alias addr_err=%0b rdata=%h required 0/11aa3344", addr_err, rdata);
    else passed++;
    drive(1'b1, 1'b0, 4'h0, 32'h8000_0008, 32'h0);
    drive(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    total++;
    if (addr_err !== 1'b0 || rdata !== 32'h0)
      $display("FAIL idle_after_oor addr_err=%0b rdata=%h required 0/0", addr_err, rdata);
    else passed++;
  endtask

  task automatic test_back_to_back();
    logic [31:0] d;
    for (int i = 0; i < 8; i++) begin
      d = $urandom;
      drive(1'b1, 1'b1, 4'($urandom_range(1, 15)), 32'(4 * (i + 4)), d);
      drive(1'b1, 1'b0, 4'h0, 32'(4 * (i + 4)), 32'h0);
      total++;
      if (rdata !== ref_rdata) $display("FAIL back_to_back word %0d got %h required %h", i + 4, rdata, ref_rdata);
      else passed++;
    end
  endtask

  task automatic test_random();
    logic [31:0] a;
    for (int k = 0; k < 200; k++) begin
      if ($urandom_range(0, 7) == 0) a = $urandom | (32'h1 << $urandom_range(AW + 2, 31));
      else a = 32'($urandom_range(0, 4 * WORDS - 1));
      drive(1'($urandom_range(0, 3) != 0), 1'($urandom), 4'($urandom), a, $urandom);
      total++;
      if (rdata !== ref_rdata || addr_err !== ref_err)
        $display("FAIL random #%0d rdata=%h err=%0b required %h/%0b", k, rdata, addr_err, ref_rdata, ref_err);
      else passed++;
    end
  endtask

  task automatic test_reset_mid_clear();
    drive(1'b1, 1'b0, 4'h0, 32'h4, 32'h0);
    rst = 1'b1;
    #2;
    total++;
    if (rdata !== 32'h0 || addr_err !== 1'b0)
      $display("FAIL async_reset rdata=%h addr_err=%0b required 0/0", rdata, addr_err);
    else passed++;
    @(posedge clk);
    #1;
    release_reset();
`ifdef DSRAM_CLEAR_EN
    begin
      int n;
      repeat (7) begin
        @(posedge clk);
        #1;
      end
      rst = 1'b1;
      #2;
      total++;
      if (busy !== 1'b1) $display("FAIL mid_clear_busy got %0b required 1", busy);
      else passed++;
      @(posedge clk);
      #1;
      release_reset();
      wait_clear(n);
      total++;
      if (n != WORDS) $display("FAIL restart_clear_length got %0d required %0d", n, WORDS);
      else passed++;
      for (int i = 0; i < WORDS; i++) ref_mem[i] = 32'h0;
      drive(1'b1, 1'b0, 4'h0, 32'h8, 32'h0);
      total++;
      if (rdata !== 32'h0) $display("FAIL busy_write_dropped got %h required 0", rdata);
      else passed++;
      drive(1'b1, 1'b0, 4'h0, 32'h4, 32'h0);
      total++;
      if (rdata !== 32'h0) $display("FAIL restart_cleared got %h required 0", rdata);
      else passed++;
    end
`else
    total++;
    if (busy !== 1'b0) $display("FAIL reset_busy_low got %0b required 0", busy);
    else passed++;
    for (int i = 0; i < WORDS; i++) drive(1'b1, 1'b1, 4'hF, 32'(4 * i), $urandom);
`endif
  endtask

  initial begin
    test_reset();
    test_startup();
    test_full_write();
    test_byte_lanes();
    test_out_of_range();
    test_back_to_back();
    test_random();
    test_reset_mid_clear();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
